// File: rtl/qpsk_mapper.sv
// Serial-bit to QPSK mapper: pairs bits MSB-first into symbols and emits
// framed signed I/Q points through a single output register with valid/ready.
module qpsk_mapper #(
    parameter logic signed [15:0] AMP   = 16'sd11585,
    parameter int                 N_SC  = 64,
    parameter int                 IDX_W = $clog2(N_SC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic signed [15:0]      I_out,
    output logic signed [15:0]      Q_out,
    output logic                    data_valid,
    input  logic                    out_ready,
    output logic                    sof,
    output logic                    eof,
    output logic [IDX_W-1:0]        sym_idx
);
    localparam int               DATA_W   = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SC - 1);

    function automatic logic signed [DATA_W-1:0] map_rail(input logic b);
        return b ? AMP : -AMP;
    endfunction

    logic                     phase_p0;
    logic                     msb_p0;
    logic [IDX_W-1:0]         cnt_p0;

    logic signed [DATA_W-1:0] i_p1;
    logic signed [DATA_W-1:0] q_p1;
    logic                     vld_p1;
    logic                     sof_p1;
    logic                     eof_p1;
    logic [IDX_W-1:0]         idx_p1;

    logic                     msb_take;
    logic                     lsb_take;
    logic                     xfer;

    // The MSB slot never stalls; only the LSB needs room in the output register.
    assign bit_ready = !phase_p0 || !vld_p1 || out_ready;
    assign msb_take  = bit_valid && !clr && !phase_p0;
    assign lsb_take  = bit_valid && !clr &&  phase_p0 && bit_ready;
    assign xfer      = vld_p1 && out_ready;

    // Stage p0: bit pairing and frame counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_p0 <= 1'b0;
            msb_p0   <= 1'b0;
            cnt_p0   <= '0;
        end else if (clr) begin
            phase_p0 <= 1'b0;
            cnt_p0   <= '0;
        end else if (msb_take) begin
            msb_p0   <= bit_in;
            phase_p0 <= 1'b1;
        end else if (lsb_take) begin
            phase_p0 <= 1'b0;
            cnt_p0   <= (cnt_p0 == LAST_IDX) ? '0 : cnt_p0 + 1'b1;
        end
    end

    // Stage p1: output register, loads on LSB accept, held while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_p1   <= '0;
            q_p1   <= '0;
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
            eof_p1 <= 1'b0;
            idx_p1 <= '0;
        end else if (clr) begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
            eof_p1 <= 1'b0;
        end else if (lsb_take) begin
            i_p1   <= map_rail(msb_p0);
            q_p1   <= map_rail(bit_in);
            vld_p1 <= 1'b1;
            sof_p1 <= (cnt_p0 == '0);
            eof_p1 <= (cnt_p0 == LAST_IDX);
            idx_p1 <= cnt_p0;
        end else if (xfer) begin
            vld_p1 <= 1'b0;
        end
    end

    assign I_out      = i_p1;
    assign Q_out      = q_p1;
    assign data_valid = vld_p1;
    assign sof        = sof_p1;
    assign eof        = eof_p1;
    assign sym_idx    = idx_p1;

endmodule

// File: tb/tb_qpsk_mapper.sv
// Bench for qpsk_mapper: vector table plus scoreboard of expected I/Q points,
// covering framing, backpressure, async reset, clr and a demodulator loopback.
module tb_qpsk_mapper;
    localparam int N_SC = 64;

    logic               clk;
    logic               rst;
    logic               clr;
    logic               bit_in;
    logic               bit_valid;
    logic               bit_ready;
    logic signed [15:0] I_out;
    logic signed [15:0] Q_out;
    logic               data_valid;
    logic               out_ready;
    logic               sof;
    logic               eof;
    logic [5:0]         sym_idx;

    qpsk_mapper #(.AMP(16'sd11585), .N_SC(N_SC)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .I_out(I_out), .Q_out(Q_out), .data_valid(data_valid),
        .out_ready(out_ready), .sof(sof), .eof(eof), .sym_idx(sym_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic               sof;
        logic               eof;
        logic [5:0]         idx;
    } pt_t;

    typedef struct {
        logic [1:0]         sym;
        logic signed [15:0] i;
        logic signed [15:0] q;
    } vec_t;

    pt_t        sb[$];
    logic [1:0] tx_syms[$];
    logic [1:0] rx_syms[$];
    vec_t       vecs[4];
    pt_t        mon_e;

    int   checks;
    int   failures;
    int   cyc;
    logic m_phase;
    logic m_msb;
    int   m_idx;
    logic rnd_ready;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] amp(input logic b);
        return b ? 16'sd11585 : -16'sd11585;
    endfunction

    function automatic logic [1:0] demod(input logic signed [15:0] i, input logic signed [15:0] q);
        return {(i > 0), (q > 0)};
    endfunction

    task automatic model_reset();
        m_phase = 1'b0;
        m_msb   = 1'b0;
        m_idx   = 0;
        sb.delete();
    endtask

    task automatic model_accept(input logic b);
        pt_t p;
        if (!m_phase) begin
            m_msb   = b;
            m_phase = 1'b1;
        end else begin
            p.i   = amp(m_msb);
            p.q   = amp(b);
            p.sof = (m_idx == 0);
            p.eof = (m_idx == N_SC - 1);
            p.idx = 6'(m_idx);
            sb.push_back(p);
            tx_syms.push_back({m_msb, b});
            m_idx   = (m_idx + 1) % N_SC;
            m_phase = 1'b0;
        end
    endtask

    // Presents one bit until accepted; returns #1 after the accepting edge.
    task automatic send_bit(input logic b);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            acc = bit_ready;
            @(posedge clk);
        end
        #1;
        bit_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_bit: bit_ready never high, got 0 expected 1 (t=%0t)", $time);
        end else begin
            model_accept(b);
        end
    endtask

    task automatic send_rand_pair();
        send_bit(1'($urandom & 1));
        send_bit(1'($urandom & 1));
    endtask

    always @(negedge clk) begin
        if (rnd_ready) out_ready = 1'($urandom & 1);
    end

    // Output monitor: every transfer pops and compares one expected point.
    always @(negedge clk) begin
        #2;
        if (rst && !clr && data_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_point: got idx %0d expected no output", sym_idx);
            end else begin
                mon_e = sb.pop_front();
                chk("mon_I", I_out, mon_e.i);
                chk("mon_Q", Q_out, mon_e.q);
                chk("mon_sof", sof, mon_e.sof);
                chk("mon_eof", eof, mon_e.eof);
                chk("mon_idx", sym_idx, mon_e.idx);
                rx_syms.push_back(demod(I_out, Q_out));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rnd_ready = 1'b0;
        rst       = 1'b0;
        clr       = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_I", I_out, 0);
        chk("rst_Q", Q_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_sof", sof, 0);
        chk("rst_eof", eof, 0);
        chk("rst_idx", sym_idx, 0);
        chk("rst_ready", bit_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // Constellation table, bits 1,1,0,1,1,0,0,0
        vecs[0] = '{2'b11,  16'sd11585,  16'sd11585};
        vecs[1] = '{2'b01, -16'sd11585,  16'sd11585};
        vecs[2] = '{2'b10,  16'sd11585, -16'sd11585};
        vecs[3] = '{2'b00, -16'sd11585, -16'sd11585};
        for (int i = 0; i < 4; i++) begin
            send_bit(vecs[i].sym[1]);
            chk("t1_valid_after_msb", data_valid, 0);
            send_bit(vecs[i].sym[0]);
            chk("t1_valid", data_valid, 1);
            chk("t1_I", I_out, vecs[i].i);
            chk("t1_Q", Q_out, vecs[i].q);
            chk("t1_idx", sym_idx, i);
            chk("t1_sof", sof, (i == 0));
        end

        // Continuous stream across a frame boundary at full rate
        c0 = cyc;
        repeat (70) send_rand_pair();
        chk("t2_throughput_cycles", cyc - c0, 140);

        // Stall: MSB still accepted, LSB blocked, output held, no bubble on release
        out_ready = 1'b0;
        send_bit(1'b1);
        chk("t3_ready_stalled", bit_ready, 0);
        @(negedge clk);
        bit_in    = 1'b0;
        bit_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_ready_hold", bit_ready, 0);
            chk("t3_valid_hold", data_valid, 1);
            chk("t3_I_hold", I_out, sb[0].i);
            chk("t3_Q_hold", Q_out, sb[0].q);
            chk("t3_idx_hold", sym_idx, sb[0].idx);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_ready_release", bit_ready, 1);
        @(posedge clk);
        model_accept(1'b0);
        #1;
        bit_valid = 1'b0;
        chk("t3_no_bubble_valid", data_valid, 1);
        chk("t3_no_bubble_idx", sym_idx, sb[0].idx);
        chk("t3_no_bubble_I", I_out, sb[0].i);

        // Async reset with only an MSB collected
        send_bit(1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("t4a_valid", data_valid, 0);
        chk("t4a_I", I_out, 0);
        chk("t4a_idx", sym_idx, 0);
        chk("t4a_ready", bit_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t4a_first_idx", sym_idx, 0);
        chk("t4a_first_sof", sof, 1);
        chk("t4a_first_I", I_out, -11585);
        chk("t4a_first_Q", Q_out, 11585);

        // Async reset with a stalled point pending
        out_ready = 1'b0;
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("t4b_valid", data_valid, 0);
        chk("t4b_I", I_out, 0);
        chk("t4b_Q", Q_out, 0);
        chk("t4b_sof", sof, 0);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        chk("t4b_first_idx", sym_idx, 0);
        chk("t4b_first_sof", sof, 1);

        // clr mid-frame with a pending point and a presented bit
        while (m_idx != 37) send_rand_pair();
        send_bit(1'b1);
        out_ready = 1'b0;
        send_bit(1'b1);
        chk("t5_pending_idx", sym_idx, 37);
        chk("t5_pending_valid", data_valid, 1);
        @(negedge clk);
        clr       = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        #1;
        chk("t5_ready_during_clr", bit_ready, 1);
        @(posedge clk);
        #1;
        clr       = 1'b0;
        bit_valid = 1'b0;
        sb.delete();
        m_idx   = 0;
        m_phase = 1'b0;
        chk("t5_valid_cleared", data_valid, 0);
        chk("t5_sof_cleared", sof, 0);
        out_ready = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t5_next_idx", sym_idx, 0);
        chk("t5_next_sof", sof, 1);
        chk("t5_next_I", I_out, -11585);
        chk("t5_next_Q", Q_out, 11585);

        // Loopback through a hard-decision demodulator under random backpressure
        repeat (3) @(negedge clk);
        chk("t6_drained", sb.size(), 0);
        tx_syms.delete();
        rx_syms.delete();
        rnd_ready = 1'b1;
        repeat (128) send_rand_pair();
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_count", rx_syms.size(), tx_syms.size());
        chk("t6_tx_count", tx_syms.size(), 128);
        for (int k = 0; k < 128 && k < rx_syms.size(); k++) begin
            chk("t6_loopback_sym", rx_syms[k], tx_syms[k]);
        end

        chk("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qpsk_mapper.md
Name: qpsk_mapper

Overview:
Transmit-side QPSK mapper and the exact inverse of the receive-chain hard-decision QPSK demodulator. It accepts a serial bit stream over a valid/ready handshake and pairs the bits MSB-first into 2-bit symbols. Each symbol becomes a signed 16-bit I/Q constellation point, and points are grouped into OFDM frames of N_SC subcarriers with start/end markers. It sits between the bit source/scrambler and the IFFT input buffer.

Parameters:
AMP, 16'sd11585, constellation magnitude (0.7071 in Q1.14), applied as +AMP/-AMP on each rail; must be >0.
N_SC, 64, symbols per OFDM frame; legal range 2..4096.
IDX_W, $clog2(N_SC), width of sym_idx.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
clr  input  1  synchronous clear of pairing phase, frame counter and output valid
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is valid this cycle
bit_ready  output  1  mapper accepts bit_in this cycle (combinational)
I_out  output  16  signed in-phase sample
Q_out  output  16  signed quadrature sample
data_valid  output  1  I_out/Q_out/sof/eof/sym_idx are valid
out_ready  input  1  downstream accepts the current output
sof  output  1  current output is subcarrier 0 of a frame
eof  output  1  current output is subcarrier N_SC-1 of a frame
sym_idx  output  IDX_W  subcarrier index of the current output

Behaviour:
- Reset (rst=0, async). Forces I_out=0, Q_out=0, data_valid=0, sof=0, eof=0, sym_idx=0, internal phase=0, msb_hold=0 and frame counter=0. bit_ready is therefore 1.
- Bit accept: occurs when bit_valid && bit_ready at the clock edge.
- Phase 0 (awaiting MSB): bit_ready=1 always. An accepted bit is stored in msb_hold and phase goes to 1. This is allowed even while the output is stalled.
- Phase 1 (awaiting LSB): bit_ready = !data_valid || out_ready. An accepted bit forms sym={msb_hold,bit_in}, phase returns to 0, and the output register loads on the same edge.
- Mapping: sym[1]=1 gives I_out=+AMP, else -AMP. sym[0]=1 gives Q_out=+AMP, else -AMP. Result: sym 3 gives (+,+), 2 gives (+,-), 1 gives (-,+), 0 gives (-,-). This inverts the receive demodulator.
- Latency: data_valid rises on the edge that accepts the LSB, so the point is visible one cycle after the LSB handshake.
- Output handshake: the output transfers when data_valid && out_ready.
  - While data_valid && !out_ready, I_out, Q_out, sof, eof and sym_idx hold stable.
  - If a transfer and a new load happen on the same edge, the new point replaces the old one with no bubble. Full throughput is one symbol per 2 bit cycles.
  - A transfer with no new load clears data_valid.
- Frame counter: sym_idx is loaded from the counter with each new point. sof=(counter==0), eof=(counter==N_SC-1). The counter increments on each load and wraps N_SC-1 to 0.
- clr: synchronous and takes priority over any accept.
  - Sets phase=0, counter=0, data_valid=0, sof=0, eof=0.
  - Leaves I_out/Q_out values don't-care.
  - A bit presented with clr is not accepted, even though bit_ready may be high. The source must treat a clr cycle as a non-handshake.
- Reset mid-operation: any half-collected pair and any pending output are discarded. The next accepted bit is an MSB and the next point has sof=1.
- No internal buffering beyond one output register and one MSB hold. Upstream sees backpressure only in phase 1.

Test Plan:
1. Reset, out_ready=1, stream bits 1,1,0,1,1,0,0,0 -> four points (+11585,+11585), (-11585,+11585), (+11585,-11585), (-11585,-11585), each valid one cycle after its LSB, sym_idx 0..3, sof on first only.
2. N_SC=4, stream 10 symbols continuously -> sym_idx 0,1,2,3,0,1,2,3,0,1; eof at idx 3; sof at idx 0 each frame; no gap between frames.
3. Hold out_ready=0 after the first point, keep bit_valid=1 -> MSB accepted, then bit_ready=0 in phase 1. Output holds stable. Raising out_ready loads the next point on the transfer edge with no bubble.
4. Assert rst low after the MSB only and with a stalled point pending -> all outputs 0 immediately (async). After release, the first pair gives sym_idx=0, sof=1.
5. Assert clr mid-frame (sym_idx=37, N_SC=64) with a bit presented -> bit dropped, data_valid=0. The next point has sym_idx=0, sof=1.
6. Loopback through the receive demodulator with 256 random bits -> recovered symbols match the transmitted pairs exactly, in order.
